// File: rtl/spi_target_pkg.sv
// Shared constants for the SPI target peripheral: register offsets,
// status/control bit positions and the underrun fill byte.
package spi_target_pkg;
  localparam logic       REG_DATA = 1'b0;
  localparam logic       REG_STAT = 1'b1;

  localparam int ST_RX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_OVERRUN  = 2;
  localparam int ST_UNDERRUN = 3;
  localparam int ST_SELECTED = 4;
  localparam int ST_RXIE     = 5;
  localparam int ST_TXIE     = 6;
  localparam int ST_IRQ      = 7;

  localparam int CTRL_RXIE = 0;
  localparam int CTRL_TXIE = 1;
  localparam int CTRL_CLR  = 6;

  localparam logic [7:0] UNDERRUN_FILL = 8'hFF;
endpackage

// File: rtl/spi_target_sync_edge.sv
// 2-FF synchronizer plus edge register; rise/fall pulse one clk per pin edge.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic rise,
  output logic fall
);
  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh <= {3{RST_VAL}};
    else        sh <= {sh[1:0], pin};

  assign rise =  sh[1] & ~sh[2];
  assign fall = ~sh[1] &  sh[2];
endmodule

// File: rtl/spi_target.sv
// Mode-0 SPI target on the CPU bus: one buffered byte each way, status,
// error flags and interrupt. All SPI pins are resampled into clk.
module spi_target
  import spi_target_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic       rs,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe
);
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [1:0] mosi_sync;
  logic       active;
  logic [3:0] count;
  logic [7:0] rx_shift, tx_shift, rx_data, tx_hold;
  logic       rx_full, tx_empty, overrun, underrun, rxie, txie;
  logic       rd_data, wr_data, wr_ctrl;
  logic       sclk_up, sclk_dn, byte_done, tx_load;
  logic [7:0] rx_byte, tx_next, stat;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst), .pin(spi_sclk), .rise(sclk_rise), .fall(sclk_fall));
  // cs_n idles high so reset must not produce a phantom select edge
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst), .pin(spi_cs_n), .rise(cs_rise), .fall(cs_fall));

  // MOSI taken from the second stage, same depth as the sclk edge decision
  always_ff @(posedge clk or negedge rst)
    if (!rst) mosi_sync <= 2'b00;
    else      mosi_sync <= {mosi_sync[0], spi_mosi};

  assign rd_data   = cs & ~we & (rs == REG_DATA);
  assign wr_data   = cs &  we & (rs == REG_DATA);
  assign wr_ctrl   = cs &  we & (rs == REG_STAT);
  assign sclk_up   = active & sclk_rise;
  assign sclk_dn   = active & sclk_fall;
  assign byte_done = sclk_up & (count == 4'd7);
  assign rx_byte   = {rx_shift[6:0], mosi_sync[1]};
  assign tx_load   = cs_fall | (sclk_dn & (count == 4'd8));
  assign tx_next   = tx_empty ? UNDERRUN_FILL : tx_hold;
  assign spi_miso  = tx_shift[7];

  always_comb begin
    stat              = '0;
    stat[ST_RX_FULL]  = rx_full;
    stat[ST_TX_EMPTY] = tx_empty;
    stat[ST_OVERRUN]  = overrun;
    stat[ST_UNDERRUN] = underrun;
    stat[ST_SELECTED] = active;
    stat[ST_RXIE]     = rxie;
    stat[ST_TXIE]     = txie;
    stat[ST_IRQ]      = irq;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      active <= 1'b0; count <= '0; spi_miso_oe <= 1'b0;
      rx_shift <= '0; tx_shift <= '0; rx_data <= '0; tx_hold <= '0;
      rx_full <= 1'b0; tx_empty <= 1'b1; overrun <= 1'b0; underrun <= 1'b0;
      rxie <= 1'b0; txie <= 1'b0; irq <= 1'b0; dout <= '0;
    end else begin
      if (cs_fall) begin
        active <= 1'b1; count <= '0; spi_miso_oe <= 1'b1;
      end else if (cs_rise) begin
        active <= 1'b0; count <= '0; spi_miso_oe <= 1'b0;
      end else if (sclk_up) begin
        rx_shift <= rx_byte;
        count    <= count + 4'd1;
      end else if (sclk_dn && count == 4'd8) begin
        count <= '0;
      end

      if (tx_load)      tx_shift <= tx_next;
      else if (sclk_dn) tx_shift <= {tx_shift[6:0], 1'b0};

      // Clears first, then sets, so a same-cycle set always wins
      if (wr_ctrl) begin
        rxie <= din[CTRL_RXIE];
        txie <= din[CTRL_TXIE];
        if (din[CTRL_CLR]) begin overrun <= 1'b0; underrun <= 1'b0; end
      end
      if (rd_data) rx_full <= 1'b0;
      if (byte_done) begin
        rx_full <= 1'b1;
        if (!rx_full || rd_data) rx_data <= rx_byte;
        else                     overrun <= 1'b1;
      end
      if (tx_load) begin
        tx_empty <= 1'b1;
        if (tx_empty) underrun <= 1'b1;
      end
      // A CPU write lands after the load has taken the old tx_hold
      if (wr_data) begin
        tx_hold  <= din;
        tx_empty <= 1'b0;
      end

      irq  <= (rxie & rx_full) | (txie & tx_empty);
      dout <= rs ? stat : rx_data;
    end
endmodule
